alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 4..32, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B (shift amount = b[SHW-1:0]).
REQ-009 opcode  input  4  operation select (REQ-014).
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero, carry, neg, ovf  output  1 each  registered flags.

Function
REQ-014 Opcodes SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt signed, 0101 beq, 0110 bne, 0111 xor, 1000 sltu, 1001 sll, 1010 srl, 1011 sra, 1100 mul (REQ-030), others -> result 0.
REQ-015 FSM SHALL have states IDLE, SHIFT, MUL, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Transfer on in_valid&in_ready: single-cycle ops -> DONE; sll/srl/sra with shamt!=0 -> SHIFT; mul -> MUL; shamt=0 -> DONE with result=a.
REQ-017 Single-cycle ops SHALL assert out_valid the cycle after acceptance (latency 1).
REQ-018 SHIFT SHALL move one bit per cycle, decrementing a counter; result valid shamt+1 cycles after acceptance; sra replicates a[WIDTH-1].
REQ-019 In DONE, out_valid=1 and result/flags SHALL hold stable until out_ready=1; then next state IDLE (one bubble; no accept in same cycle).
REQ-020 add/sub SHALL compute WIDTH+1 bits; carry = bit WIDTH (sub: carry=1 means borrow, a<b unsigned); ovf = signed overflow; other ops carry=ovf=0.
REQ-021 slt/sltu result SHALL be 1 (zero-extended) when a<b signed/unsigned, else 0.
REQ-022 beq/bne SHALL set result=0 and zero=(a==b) / (a!=b); all other ops zero=(result==0).
REQ-023 neg SHALL equal result[WIDTH-1] for all ops.
REQ-024 in_valid while in_ready=0 SHALL be ignored; a, b, opcode SHALL be captured at acceptance and later input changes SHALL not affect the result.
REQ-025 Undefined opcodes SHALL complete in 1 cycle with result=0, zero=1, other flags 0.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, out_valid=0, result=0, all flags 0, counters 0.
REQ-027 Reset mid-SHIFT/MUL/DONE SHALL abandon the operation with no output; in_ready=1 the first cycle after rst_n rises.
REQ-028 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN SHALL compile in the multiply datapath.
REQ-030 With ALU_SEQ_MUL_EN: opcode 1100 SHALL do unsigned shift-add multiply, one partial product per cycle, WIDTH cycles in MUL, out_valid WIDTH+1 cycles after acceptance, result=low WIDTH bits, carry=ovf=(high WIDTH bits !=0).
REQ-031 Without ALU_SEQ_MUL_EN: MUL state and datapath SHALL be absent; 1100 SHALL behave as undefined (REQ-025).

Verification (WIDTH=8)
REQ-032 add a=0xFF b=0x01, out_ready=1 -> next cycle out_valid=1, result=0x00, zero=1, carry=1, ovf=0.
REQ-033 add a=0x7F b=0x01 -> result=0x80, neg=1, ovf=1, carry=0; slt a=0xFE b=0x01 -> result=1; sltu same -> result=0.
REQ-034 beq a=b=0x5A -> result=0, zero=1; bne same -> zero=0; sub a=0x03 b=0x05 -> result=0xFE, carry=1.
REQ-035 sra a=0x80 b=0x03 -> in_ready=0 for 3 cycles, out_valid on cycle 4, result=0xF0; out_ready held 0 for 5 cycles -> result stable, in_ready=0.
REQ-036 mul a=0x10 b=0x11 with ALU_SEQ_MUL_EN -> out_valid after 9 cycles, result=0x10, carry=ovf=1; without macro -> 1 cycle, result=0, zero=1.
REQ-037 rst_n pulsed low during SHIFT of sll a=0x01 b=0x07 -> out_valid never asserts, in_ready=1 the cycle after release, next add 0x02+0x03 -> 0x05.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops, bit-serial shifts and an
// optional shift-add multiplier (compiled in by defining ALU_SEQ_MUL_EN).
`default_nettype none

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_SLT  = 4'b0100;
    localparam logic [3:0] c_OP_BEQ  = 4'b0101;
    localparam logic [3:0] c_OP_BNE  = 4'b0110;
    localparam logic [3:0] c_OP_XOR  = 4'b0111;
    localparam logic [3:0] c_OP_SLTU = 4'b1000;
    localparam logic [3:0] c_OP_SLL  = 4'b1001;
    localparam logic [3:0] c_OP_SRL  = 4'b1010;
    localparam logic [3:0] c_OP_SRA  = 4'b1011;
    localparam logic [SHW:0] c_CNT_ONE = {{SHW{1'b0}}, 1'b1};
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0]   c_OP_MUL   = 4'b1100;
    localparam logic [SHW:0] c_MUL_LAST = (SHW+1)'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        S_MUL   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_zero, r_carry, r_neg, r_ovf;
    logic [SHW:0]     r_cnt;

    logic             w_accept;
    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [WIDTH-1:0] w_alu_res, w_sh_next;
    logic             w_alu_c, w_alu_v, w_alu_z, w_use_cmp, w_cmp_z;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_mc, r_prod, w_prod_nxt;
    logic [WIDTH-1:0]   r_mp;
    assign w_prod_nxt = r_prod + (r_mp[0] ? r_mc : '0);
`endif

    assign in_ready   = rst_n && (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_shamt    = b[SHW-1:0];
    assign w_is_shift = (opcode == c_OP_SLL) || (opcode == c_OP_SRL) || (opcode == c_OP_SRA);
    assign result     = r_res;
    assign zero       = r_zero;
    assign carry      = r_carry;
    assign neg        = r_neg;
    assign ovf        = r_ovf;

    // Single-cycle ALU; shift ops pass a through so shamt=0 completes directly.
    always_comb begin
        w_sum     = {1'b0, a} + {1'b0, b};
        w_dif     = {1'b0, a} - {1'b0, b};
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_use_cmp = 1'b0;
        w_cmp_z   = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_dif[WIDTH-1:0];
                w_alu_c   = w_dif[WIDTH];
                w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_AND:  w_alu_res = a & b;
            c_OP_OR:   w_alu_res = a | b;
            c_OP_XOR:  w_alu_res = a ^ b;
            c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            c_OP_BEQ: begin
                w_use_cmp = 1'b1;
                w_cmp_z   = (a == b);
            end
            c_OP_BNE: begin
                w_use_cmp = 1'b1;
                w_cmp_z   = (a != b);
            end
            c_OP_SLL, c_OP_SRL, c_OP_SRA: w_alu_res = a;
            default:   w_alu_res = '0;
        endcase
        w_alu_z = w_use_cmp ? w_cmp_z : (w_alu_res == '0);
    end

    always_comb begin
        case (r_op)
            c_OP_SLL: w_sh_next = {r_res[WIDTH-2:0], 1'b0};
            c_OP_SRL: w_sh_next = {1'b0, r_res[WIDTH-1:1]};
            default:  w_sh_next = {r_res[WIDTH-1], r_res[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) w_state_nxt = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
                    else if (opcode == c_OP_MUL)      w_state_nxt = S_MUL;
`endif
                    else                              w_state_nxt = S_DONE;
                end
            end
            S_SHIFT: if (r_cnt == c_CNT_ONE) w_state_nxt = S_DONE;
`ifdef ALU_SEQ_MUL_EN
            S_MUL:   if (r_cnt == c_MUL_LAST) w_state_nxt = S_DONE;
`endif
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_mc    <= '0;
            r_mp    <= '0;
            r_prod  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= opcode;
                        r_res   <= w_alu_res;
                        r_zero  <= w_alu_z;
                        r_carry <= w_alu_c;
                        r_neg   <= w_alu_res[WIDTH-1];
                        r_ovf   <= w_alu_v;
                        r_cnt   <= {1'b0, w_shamt};
`ifdef ALU_SEQ_MUL_EN
                        r_mc    <= {{WIDTH{1'b0}}, a};
                        r_mp    <= b;
                        r_prod  <= '0;
                        if (opcode == c_OP_MUL) r_cnt <= '0;
`endif
                    end
                end
                S_SHIFT: begin
                    r_res  <= w_sh_next;
                    r_zero <= (w_sh_next == '0);
                    r_neg  <= w_sh_next[WIDTH-1];
                    r_cnt  <= r_cnt - c_CNT_ONE;
                end
`ifdef ALU_SEQ_MUL_EN
                // One partial product per cycle; flags track the running product.
                S_MUL: begin
                    r_prod  <= w_prod_nxt;
                    r_mc    <= {r_mc[2*WIDTH-2:0], 1'b0};
                    r_mp    <= {1'b0, r_mp[WIDTH-1:1]};
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    r_res   <= w_prod_nxt[WIDTH-1:0];
                    r_zero  <= (w_prod_nxt[WIDTH-1:0] == '0);
                    r_neg   <= w_prod_nxt[WIDTH-1];
                    r_carry <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                    r_ovf   <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
